// File: rtl/rtc_timekeeper.sv
// Time-of-day core: 24-hour BCD hh:mm:ss with 12/24-hour presentation, alarm,
// and debounced function/up/down keys with auto-repeat on up/down.
module rtc_timekeeper #(
    parameter int CLK_HZ              = 50000000,
    parameter int DEBOUNCE_CYCLES     = 750000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 12500000,
    parameter int ALARM_RING_SEC      = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_func_n,
    input  logic        key_up_n,
    input  logic        key_down_n,
    input  logic        mode_12h,
    input  logic        alarm_en,
    output logic [23:0] time_bcd,
    output logic [15:0] alarm_bcd,
    output logic        pm,
    output logic [2:0]  state,
    output logic        sec_pulse,
    output logic        blink,
    output logic        alarm_ring
);

    localparam int PW      = $clog2(CLK_HZ + 1);
    localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam int AW      = $clog2(ALARM_RING_SEC + 1);

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_HR      = 3'd1,
        SET_MIN     = 3'd2,
        SET_ALM_HR  = 3'd3,
        SET_ALM_MIN = 3'd4
    } state_t;

    state_t          st;
    logic [PW-1:0]   presc;
    logic [5:0]      hr;
    logic [6:0]      mn;
    logic [6:0]      sc;
    logic [5:0]      ahr;
    logic [6:0]      amn;
    logic            ring;
    logic [AW-1:0]   ring_cnt;

    // Key bit order: [0] func, [1] up, [2] down
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      db_level;
    logic [2:0]      press;
    logic [DBW-1:0]  db_cnt [3];

    // Repeat bit order: [0] up, [1] down
    logic [RW-1:0]   rep_cnt [2];
    logic [1:0]      rep_ph;
    logic [1:0]      held;
    logic [1:0]      rep_fire;
    logic [1:0]      step;
    logic            both_held;

    logic [6:0]      nxt_sc;
    logic [6:0]      nxt_mn;
    logic [5:0]      nxt_hr;
    logic            trig;
    logic            func_press;
    logic            adv;
    logic            consume;
    logic [5:0]      hr_pres;
    logic [5:0]      ahr_pres;

    function automatic logic [5:0] hr_inc(input logic [5:0] h);
        if (h == 6'h23)           return 6'h00;
        else if (h[3:0] == 4'd9)  return {h[5:4] + 2'd1, 4'd0};
        else                      return {h[5:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [5:0] hr_dec(input logic [5:0] h);
        if (h == 6'h00)           return 6'h23;
        else if (h[3:0] == 4'd0)  return {h[5:4] - 2'd1, 4'd9};
        else                      return {h[5:4], h[3:0] - 4'd1};
    endfunction

    function automatic logic [6:0] min_inc(input logic [6:0] m);
        if (m == 7'h59)           return 7'h00;
        else if (m[3:0] == 4'd9)  return {m[6:4] + 3'd1, 4'd0};
        else                      return {m[6:4], m[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] min_dec(input logic [6:0] m);
        if (m == 7'h00)           return 7'h59;
        else if (m[3:0] == 4'd0)  return {m[6:4] - 3'd1, 4'd9};
        else                      return {m[6:4], m[3:0] - 4'd1};
    endfunction

    // 24h BCD hour to presented hour; 13..23 map to 01..11 in BCD
    function automatic logic [5:0] to_pres(input logic [5:0] h, input logic m12);
        if (!m12)                 return h;
        else if (h == 6'h00)      return 6'h12;
        else if (h <= 6'h12)      return h;
        else if (h[5:4] == 2'd1)  return {2'd0, h[3:0] - 4'd2};
        else if (h[3:0] < 4'd2)   return {2'd0, h[3:0] + 4'd8};
        else                      return {2'd1, h[3:0] - 4'd2};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '1;
            sync2    <= '1;
            db_level <= '1;
            press    <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {key_down_n, key_up_n, key_func_n};
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= sync2[i];
                    press[i]    <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        held      = {~db_level[2], ~db_level[1]};
        both_held = held[0] & held[1];
        rep_fire  = '0;
        step      = '0;
        for (int i = 0; i < 2; i++) begin
            rep_fire[i] = rep_ph[i] ? (rep_cnt[i] == RW'(REPEAT_RATE_CYCLES - 1))
                                    : (rep_cnt[i] == RW'(REPEAT_DELAY_CYCLES - 1));
            step[i]     = held[i] & ~both_held & (press[i+1] | rep_fire[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_ph <= '0;
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!held[i] || both_held || press[i+1]) begin
                    rep_cnt[i] <= '0;
                    rep_ph[i]  <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i] <= '0;
                    rep_ph[i]  <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sec_pulse  = (st == RUN) && (presc == PW'(CLK_HZ - 1));
        nxt_sc     = min_inc(sc);
        nxt_mn     = (sc == 7'h59) ? min_inc(mn) : mn;
        nxt_hr     = (sc == 7'h59 && mn == 7'h59) ? hr_inc(hr) : hr;
        trig       = sec_pulse && alarm_en && (nxt_sc == 7'h00) &&
                     (nxt_mn == amn) && (nxt_hr == ahr);
        func_press = press[0];
        consume    = func_press & ring;
        adv        = func_press & ~ring;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= RUN;
            presc    <= '0;
            hr       <= 6'h00;
            mn       <= 7'h00;
            sc       <= 7'h00;
            ahr      <= 6'h07;
            amn      <= 7'h00;
            ring     <= 1'b0;
            ring_cnt <= '0;
        end else begin
            if (sec_pulse) begin
                sc <= nxt_sc;
                mn <= nxt_mn;
                hr <= nxt_hr;
            end

            if (st == RUN && !adv) presc <= sec_pulse ? '0 : presc + 1'b1;
            else                   presc <= '0;

            case (st)
                SET_HR: begin
                    if (step[0])      hr <= hr_inc(hr);
                    else if (step[1]) hr <= hr_dec(hr);
                end
                SET_MIN: begin
                    if (step[0])      mn <= min_inc(mn);
                    else if (step[1]) mn <= min_dec(mn);
                end
                SET_ALM_HR: begin
                    if (step[0])      ahr <= hr_inc(ahr);
                    else if (step[1]) ahr <= hr_dec(ahr);
                end
                SET_ALM_MIN: begin
                    if (step[0])      amn <= min_inc(amn);
                    else if (step[1]) amn <= min_dec(amn);
                end
                default: ;
            endcase

            if (adv) begin
                case (st)
                    RUN:         st <= SET_HR;
                    SET_HR:      st <= SET_MIN;
                    SET_MIN: begin
                        st <= SET_ALM_HR;
                        sc <= 7'h00;
                    end
                    SET_ALM_HR:  st <= SET_ALM_MIN;
                    default:     st <= RUN;
                endcase
            end

            // A func press that lands on the trigger edge wins: no ring
            if (!alarm_en || consume) begin
                ring     <= 1'b0;
                ring_cnt <= '0;
            end else if (trig && !func_press) begin
                ring     <= 1'b1;
                ring_cnt <= '0;
            end else if (ring && sec_pulse) begin
                if (ring_cnt == AW'(ALARM_RING_SEC - 1)) begin
                    ring     <= 1'b0;
                    ring_cnt <= '0;
                end else begin
                    ring_cnt <= ring_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hr_pres    = to_pres(hr, mode_12h);
        ahr_pres   = to_pres(ahr, mode_12h);
        time_bcd   = {2'b00, hr_pres, 1'b0, mn, 1'b0, sc};
        alarm_bcd  = {2'b00, ahr_pres, 1'b0, amn};
        pm         = (hr >= 6'h12);
        state      = st;
        blink      = (presc < PW'(CLK_HZ / 2));
        alarm_ring = ring;
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with small timing parameters: table-driven
// vectors for the first second, auto-repeat and 12h view, plus hand sequences.
module tb_rtc_timekeeper;

    logic        clk;
    logic        rst;
    logic        key_func_n;
    logic        key_up_n;
    logic        key_down_n;
    logic        mode_12h;
    logic        alarm_en;
    logic [23:0] time_bcd;
    logic [15:0] alarm_bcd;
    logic        pm;
    logic [2:0]  state;
    logic        sec_pulse;
    logic        blink;
    logic        alarm_ring;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        exp_pulse;
        logic        exp_blink;
        logic [23:0] exp_time;
    } run_vec_t;

    typedef struct {
        int          k;
        logic [7:0]  exp_hr;
    } rep_vec_t;

    typedef struct {
        logic        mode;
        logic [23:0] exp_time;
        logic [15:0] exp_alarm;
        logic        exp_pm;
    } view_vec_t;

    run_vec_t  run_tbl  [10];
    rep_vec_t  rep_tbl  [10];
    view_vec_t view_tbl [2];

    rtc_timekeeper #(
        .CLK_HZ              (10),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (5),
        .ALARM_RING_SEC      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_func_n (key_func_n),
        .key_up_n   (key_up_n),
        .key_down_n (key_down_n),
        .mode_12h   (mode_12h),
        .alarm_en   (alarm_en),
        .time_bcd   (time_bcd),
        .alarm_bcd  (alarm_bcd),
        .pm         (pm),
        .state      (state),
        .sec_pulse  (sec_pulse),
        .blink      (blink),
        .alarm_ring (alarm_ring)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_key(input int which, input logic lvl);
        case (which)
            0:       key_func_n = lvl;
            1:       key_up_n   = lvl;
            default: key_down_n = lvl;
        endcase
    endtask

    // 0 = func, 1 = up, 2 = down; each tap is one debounced press and release
    task automatic tap(input int which, input int n);
        for (int j = 0; j < n; j++) begin
            set_key(which, 1'b0);
            ticks(8);
            set_key(which, 1'b1);
            ticks(10);
        end
    endtask

    // Returns just after the edge that applies the next second increment
    task automatic wait_pulse();
        bit seen;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (sec_pulse) seen = 1;
        end
        if (seen) begin
            tick();
        end else begin
            checks++;
            errors++;
            $display("FAIL wait_pulse: got no sec_pulse expected one within 12 cycles");
        end
    endtask

    task automatic run_until(input logic [23:0] target, input string name);
        for (int i = 0; i < 70 && time_bcd != target; i++) wait_pulse();
        check(name, time_bcd, target);
    endtask

    initial begin
        int lat;
        bit fell;

        run_tbl[0] = '{1'b0, 1'b1, 24'h000000};
        run_tbl[1] = '{1'b0, 1'b1, 24'h000000};
        run_tbl[2] = '{1'b0, 1'b1, 24'h000000};
        run_tbl[3] = '{1'b0, 1'b1, 24'h000000};
        run_tbl[4] = '{1'b0, 1'b0, 24'h000000};
        run_tbl[5] = '{1'b0, 1'b0, 24'h000000};
        run_tbl[6] = '{1'b0, 1'b0, 24'h000000};
        run_tbl[7] = '{1'b0, 1'b0, 24'h000000};
        run_tbl[8] = '{1'b1, 1'b0, 24'h000000};
        run_tbl[9] = '{1'b0, 1'b1, 24'h000001};

        rep_tbl[0] = '{19, 8'h23};
        rep_tbl[1] = '{20, 8'h00};
        rep_tbl[2] = '{24, 8'h00};
        rep_tbl[3] = '{25, 8'h01};
        rep_tbl[4] = '{29, 8'h01};
        rep_tbl[5] = '{30, 8'h02};
        rep_tbl[6] = '{35, 8'h03};
        rep_tbl[7] = '{39, 8'h03};
        rep_tbl[8] = '{40, 8'h04};
        rep_tbl[9] = '{45, 8'h04};

        view_tbl[0] = '{1'b0, 24'h000000, 16'h0001, 1'b0};
        view_tbl[1] = '{1'b1, 24'h120000, 16'h1201, 1'b0};

        rst = 1'b1;
        key_func_n = 1'b1;
        key_up_n = 1'b1;
        key_down_n = 1'b1;
        mode_12h = 1'b0;
        alarm_en = 1'b0;
        ticks(3);

        check("reset_time", time_bcd, 24'h000000);
        check("reset_alarm", alarm_bcd, 16'h0700);
        check("reset_state", state, 3'd0);
        check("reset_blink", blink, 1'b1);
        check("reset_pulse", sec_pulse, 1'b0);
        check("reset_ring", alarm_ring, 1'b0);
        check("reset_pm", pm, 1'b0);

        // First second after reset release
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("run%0d_pulse", k + 1), sec_pulse, run_tbl[k].exp_pulse);
            check($sformatf("run%0d_blink", k + 1), blink, run_tbl[k].exp_blink);
            check($sformatf("run%0d_time", k + 1), time_bcd, run_tbl[k].exp_time);
        end

        tap(0, 1);
        check("enter_set_hr", state, 3'd1);
        check("set_hr_time", time_bcd, 24'h000001);
        tap(2, 1);
        check("hr_down_wrap", time_bcd, 24'h230001);
        tap(2, 1);
        check("hr_down", time_bcd, 24'h220001);

        // Auto-repeat on a held up key
        key_up_n = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && time_bcd[23:16] != 8'h23; i++) begin
            tick();
            lat++;
        end
        check("press_latency", lat, 7);
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 36) key_up_n = 1'b1;
            for (int r = 0; r < 10; r++)
                if (rep_tbl[r].k == k)
                    check($sformatf("repeat_k%0d", k), time_bcd[23:16], rep_tbl[r].exp_hr);
        end
        ticks(10);
        check("repeat_final", time_bcd, 24'h040001);

        tap(2, 5);
        check("hr_to_23", time_bcd, 24'h230001);

        tap(0, 1);
        check("enter_set_min", state, 3'd2);
        key_up_n = 1'b0;
        ticks(3);
        key_up_n = 1'b1;
        ticks(12);
        check("glitch_no_step", time_bcd, 24'h230001);
        key_up_n = 1'b0;
        ticks(6);
        key_up_n = 1'b1;
        ticks(12);
        check("hold6_one_step", time_bcd, 24'h230101);
        tap(2, 1);
        check("min_down", time_bcd, 24'h230001);
        tap(2, 1);
        check("min_down_wrap", time_bcd, 24'h235901);

        tap(0, 1);
        check("enter_set_alm_hr", state, 3'd3);
        check("sec_cleared", time_bcd, 24'h235900);
        tap(2, 7);
        check("alm_hr_to_00", alarm_bcd, 16'h0000);
        tap(0, 1);
        check("enter_set_alm_min", state, 3'd4);
        tap(1, 1);
        check("alm_min_up", alarm_bcd, 16'h0001);
        tap(0, 1);
        check("back_to_run", state, 3'd0);

        // Rollover through midnight
        run_until(24'h235958, "reach_235958");
        wait_pulse();
        check("pre_roll", time_bcd, 24'h235959);
        check("pre_roll_pm", pm, 1'b1);
        mode_12h = 1'b1;
        #1;
        check("view12_2359", time_bcd, 24'h115959);
        mode_12h = 1'b0;
        wait_pulse();
        check("rollover", time_bcd, 24'h000000);
        for (int r = 0; r < 2; r++) begin
            mode_12h = view_tbl[r].mode;
            #1;
            check($sformatf("view%0d_time", r), time_bcd, view_tbl[r].exp_time);
            check($sformatf("view%0d_alarm", r), alarm_bcd, view_tbl[r].exp_alarm);
            check($sformatf("view%0d_pm", r), pm, view_tbl[r].exp_pm);
        end
        mode_12h = 1'b0;

        // Alarm rings for three seconds
        alarm_en = 1'b1;
        run_until(24'h000059, "reach_000059");
        check("ring_before", alarm_ring, 1'b0);
        wait_pulse();
        check("ring_time", time_bcd, 24'h000100);
        check("ring_rise", alarm_ring, 1'b1);
        wait_pulse();
        check("ring_p1", alarm_ring, 1'b1);
        wait_pulse();
        check("ring_p2", alarm_ring, 1'b1);
        wait_pulse();
        check("ring_p3_off", alarm_ring, 1'b0);

        // Move alarm to 00:02, then silence it with func
        tap(0, 3);
        check("sec_clear2", time_bcd, 24'h000100);
        tap(0, 1);
        tap(1, 1);
        check("alm_0002", alarm_bcd, 16'h0002);
        tap(0, 1);
        check("run_again", state, 3'd0);
        run_until(24'h000159, "reach_000159");
        wait_pulse();
        check("ring2_rise", alarm_ring, 1'b1);
        key_func_n = 1'b0;
        fell = 0;
        lat = 0;
        for (int i = 0; i < 15 && !fell; i++) begin
            tick();
            lat++;
            if (!alarm_ring) fell = 1;
        end
        check("silence_fell", fell, 1'b1);
        check("silence_latency", lat, 7);
        check("silence_state", state, 3'd0);
        key_func_n = 1'b1;
        ticks(12);
        check("silence_state_after", state, 3'd0);
        check("silence_ring_after", alarm_ring, 1'b0);

        // Async reset in the middle of SET_ALM_MIN with up held
        tap(0, 4);
        check("enter_alm_min2", state, 3'd4);
        key_up_n = 1'b0;
        ticks(12);
        #3;
        rst = 1'b1;
        #1;
        check("areset_time", time_bcd, 24'h000000);
        check("areset_alarm", alarm_bcd, 16'h0700);
        check("areset_state", state, 3'd0);
        check("areset_blink", blink, 1'b1);
        check("areset_pulse", sec_pulse, 1'b0);
        check("areset_ring", alarm_ring, 1'b0);
        tick();
        key_up_n = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(12);
        check("post_reset_state", state, 3'd0);
        check("post_reset_alarm", alarm_bcd, 16'h0700);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
